risc_core_param: RTL and testbench

RISC_CORE_PARAM -- requirements
Module: risc_core_param

---
 rtl/risc_core_param.sv | 141 ++++++++++++++
 tb/tb_risc_core_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/risc_core_param.sv
// Parameterised 8-phase accumulator core with built-in program/data memory.
// Optional instruction counter output enabled by defining RISC_INSTR_COUNT_EN.
module risc_core_param #(
  parameter int DATA_W = 8,  // must satisfy DATA_W >= ADDR_W + 3
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc
`ifdef RISC_INSTR_COUNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              unused_ir;

  assign opcode    = ir_q[DATA_W-1 -: 3];
  assign operand   = ir_q[ADDR_W-1:0];
  assign unused_ir = ^ir_q;

  // Phase state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= PH_INST_ADDR;
    else     phase_q <= phase_d;
  end

  // Phase next-state: freeze at OP_ADDR on HLT until go is seen
  always_comb begin
    phase_d = phase_e'(phase_q + 3'd1);
    if (halt && !go) phase_d = phase_q;
  end

  // Phase outputs
  always_comb begin
    halt = (phase_q == PH_OP_ADDR) && (opcode == OP_HLT);
  end

  // Datapath next-state
  always_comb begin
    pc_d  = pc_q;
    acc_d = acc_q;
    ir_d  = ir_q;
    mdr_d = mdr_q;
    case (phase_q)
      PH_INST_LOAD: ir_d = mem_q[pc_q];
      // HLT bumps pc on entry to OP_ADDR so it is already advanced while frozen
      PH_IDLE:      if (opcode == OP_HLT) pc_d = pc_q + ADDR_W'(1);
      PH_OP_ADDR:   if (opcode != OP_HLT) pc_d = pc_q + ADDR_W'(1);
      PH_OP_FETCH:  mdr_d = mem_q[operand];
      PH_ALU_OP: begin
        if (opcode == OP_JMP) pc_d = operand;
        else if (opcode == OP_SKZ && acc_q == '0) pc_d = pc_q + ADDR_W'(1);
      end
      PH_STORE: begin
        case (opcode)
          OP_ADD:  acc_d = acc_q + mdr_q;
          OP_AND:  acc_d = acc_q & mdr_q;
          OP_XOR:  acc_d = acc_q ^ mdr_q;
          OP_LDA:  acc_d = mdr_q;
          default: acc_d = acc_q;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      acc_q <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
    end
  end

  // Memory survives reset; host writes only while halted or in reset
  always_ff @(posedge clk) begin
    if (prog_we && (halt || rst))
      mem_q[prog_addr] <= prog_data;
    else if (!rst && phase_q == PH_STORE && opcode == OP_STO)
      mem_q[operand] <= acc_q;
  end

  assign pc  = pc_q;
  assign acc = acc_q;

`ifdef RISC_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count_q <= '0;
    else if (phase_q == PH_STORE)   count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_risc_core_param.sv
// Directed bench for risc_core_param: default 8/5 instance plus a 12/6 instance.
module tb_risc_core_param;

  logic        clk = 1'b0;
  logic        rst, go, prog_we;
  logic [4:0]  prog_addr;
  logic [7:0]  prog_data;
  logic        halt;
  logic [4:0]  pc;
  logic [7:0]  acc;

  logic        rst2, go2, prog_we2;
  logic [5:0]  prog_addr2;
  logic [11:0] prog_data2;
  logic        halt2;
  logic [5:0]  pc2;
  logic [11:0] acc2;

`ifdef RISC_INSTR_COUNT_EN
  logic [31:0] instr_count, instr_count2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_core_param dut (
    .clk(clk), .rst(rst), .go(go), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .halt(halt), .pc(pc), .acc(acc)
`ifdef RISC_INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  risc_core_param #(.DATA_W(12), .ADDR_W(6)) dut_w (
    .clk(clk), .rst(rst2), .go(go2), .prog_we(prog_we2),
    .prog_addr(prog_addr2), .prog_data(prog_data2),
    .halt(halt2), .pc(pc2), .acc(acc2)
`ifdef RISC_INSTR_COUNT_EN
    , .instr_count(instr_count2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step(1);
    prog_we = 1'b0;
  endtask

  task automatic load12(input logic [5:0] a, input logic [11:0] d);
    prog_we2 = 1'b1; prog_addr2 = a; prog_data2 = d;
    step(1);
    prog_we2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    rst2 = 1'b1; go2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = '0; prog_data2 = '0;
    step(1);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_acc", 32'(acc), 32'd0);
    check("reset_halt", 32'(halt), 32'd0);

    // HLT at address 0
    load8(5'd0, 8'h00);
    rst = 1'b0;
    step(3);
    check("hlt0_e3_halt", 32'(halt), 32'd0);
    step(1);
    check("hlt0_e4_halt", 32'(halt), 32'd1);
    check("hlt0_e4_pc", 32'(pc), 32'd1);
    step(5);
    check("hlt0_frozen_halt", 32'(halt), 32'd1);
    check("hlt0_frozen_pc", 32'(pc), 32'd1);

    // JMP 2, JMP 2, HLT
    rst = 1'b1;
    load8(5'd0, 8'hE2);
    load8(5'd1, 8'hE2);
    load8(5'd2, 8'h00);
    rst = 1'b0;
    step(11);
    check("jmp_e11_halt", 32'(halt), 32'd0);
    step(1);
    check("jmp_e12_halt", 32'(halt), 32'd1);
    check("jmp_e12_pc", 32'(pc), 32'd3);

    // LDA 7, STO 8, LDA 8, SKZ, HLT, JMP 6, HLT; acc stays 1 so SKZ does not skip
    rst = 1'b1;
    load8(5'd0, 8'hA7);
    load8(5'd1, 8'hC8);
    load8(5'd2, 8'hA8);
    load8(5'd3, 8'h20);
    load8(5'd4, 8'h00);
    load8(5'd5, 8'hE6);
    load8(5'd6, 8'h00);
    load8(5'd7, 8'h01);
    load8(5'd8, 8'h00);
    rst = 1'b0;
    step(7);
    check("lda_e7_acc", 32'(acc), 32'd0);
    step(1);
    check("lda_e8_acc", 32'(acc), 32'd1);
    step(27);
    check("sto_e35_halt", 32'(halt), 32'd0);
    step(1);
    check("sto_e36_halt", 32'(halt), 32'd1);
    check("sto_e36_pc", 32'(pc), 32'd5);
    check("sto_e36_acc", 32'(acc), 32'd1);

    // LDA 9, XOR 10, HLT; then patch mem[3]=HLT and resume in the same cycle
    rst = 1'b1;
    load8(5'd0, 8'hA9);
    load8(5'd1, 8'h8A);
    load8(5'd2, 8'h00);
    load8(5'd3, 8'hA9);
    load8(5'd9, 8'h5C);
    load8(5'd10, 8'h33);
    rst = 1'b0;
    step(20);
    check("xor_halt", 32'(halt), 32'd1);
    check("xor_pc", 32'(pc), 32'd3);
    check("xor_acc", 32'(acc), 32'h6F);
    go = 1'b1; prog_we = 1'b1; prog_addr = 5'd3; prog_data = 8'h00;
    step(1);
    go = 1'b0; prog_we = 1'b0;
    check("resume_halt_drop", 32'(halt), 32'd0);
    step(6);
    check("resume_e7_halt", 32'(halt), 32'd0);
    step(1);
    check("resume_e8_halt", 32'(halt), 32'd1);
    check("resume_e8_pc", 32'(pc), 32'd4);
`ifdef RISC_INSTR_COUNT_EN
    check("instr_count", instr_count, 32'd3);
`endif

    // LDA 9, ADD 10 (wraps), AND 11, HLT
    rst = 1'b1;
    load8(5'd0, 8'hA9);
    load8(5'd1, 8'h4A);
    load8(5'd2, 8'h6B);
    load8(5'd3, 8'h00);
    load8(5'd10, 8'hF0);
    load8(5'd11, 8'h0F);
    rst = 1'b0;
    step(8);
    check("alu_lda_acc", 32'(acc), 32'h5C);
    step(8);
    check("alu_add_wrap", 32'(acc), 32'h4C);
    step(8);
    check("alu_and_acc", 32'(acc), 32'h0C);
    step(4);
    check("alu_halt", 32'(halt), 32'd1);
    check("alu_pc", 32'(pc), 32'd4);
    rst = 1'b1;
    #1;
    check("rst_halted_halt", 32'(halt), 32'd0);
    check("rst_halted_pc", 32'(pc), 32'd0);
    check("rst_halted_acc", 32'(acc), 32'd0);
    step(1);
    rst = 1'b0;
    step(13);
    check("mid_add_acc", 32'(acc), 32'h5C);
    check("mid_add_pc", 32'(pc), 32'd2);
    rst = 1'b1;
    #1;
    check("rst_mid_acc", 32'(acc), 32'd0);
    check("rst_mid_pc", 32'(pc), 32'd0);
    check("rst_mid_halt", 32'(halt), 32'd0);
    step(1);
    // Write attempt while running must be ignored
    rst = 1'b0; prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'h00;
    step(1);
    prog_we = 1'b0;
    step(3);
    check("we_ignored_halt", 32'(halt), 32'd0);
    step(4);
    check("we_ignored_acc", 32'(acc), 32'h5C);

    // 12/6 instance: LDA FFF, ADD 1 -> 0, SKZ skips HLT@3 to HLT@4
    load12(6'd0, 12'hA0A);
    load12(6'd1, 12'h40B);
    load12(6'd2, 12'h200);
    load12(6'd3, 12'h000);
    load12(6'd4, 12'h000);
    load12(6'd10, 12'hFFF);
    load12(6'd11, 12'h001);
    rst2 = 1'b0;
    step(8);
    check("w_lda_acc", 32'(acc2), 32'hFFF);
    step(8);
    check("w_add_wrap", 32'(acc2), 32'h000);
    step(11);
    check("w_e27_halt", 32'(halt2), 32'd0);
    step(1);
    check("w_e28_halt", 32'(halt2), 32'd1);
    check("w_skip_pc", 32'(pc2), 32'd5);
    check("w_acc", 32'(acc2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
